// File: rtl/eeprom_burst_ctrl.sv
// eeprom_burst_ctrl
// Splits host burst requests into single-byte transactions for the I2C EEPROM
// byte master. Write bytes are pulled from the wd stream and read bytes are
// pushed to the rd stream. After every write byte the controller waits out the
// EEPROM internal write cycle before it issues the next transaction.
//
// Optional feature: define EEPROM_BURST_TIMEOUT_EN to enable the stuck-master
// watchdog. When the master does not report done within TIMEOUT_CYCLES of the
// m_newd rise, err is set and the rest of the burst is dropped. When the macro
// is undefined, WAIT holds indefinitely and err stays 0.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   cmd_valid/cmd_ready   burst request handshake (cmd_wr, cmd_addr, cmd_len)
//   wd_valid/wd_ready     write byte stream in (wd_data)
//   rd_valid/rd_ready     read byte stream out (rd_data)
//   busy                  burst in progress
//   err                   sticky timeout flag, cleared by the next accepted command
//   m_newd, m_wr, m_addr, m_wdata   byte request to the master
//   m_rdata, m_done       byte result from the master (m_done is in the slow domain)
module eeprom_burst_ctrl #(
    parameter int unsigned NEWD_HOLD      = 44,
    parameter int unsigned TWR_CYCLES     = 500000,
    parameter int unsigned TIMEOUT_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_wr,
    input  logic [6:0] cmd_addr,
    input  logic [3:0] cmd_len,
    input  logic       wd_valid,
    output logic       wd_ready,
    input  logic [7:0] wd_data,
    output logic       rd_valid,
    input  logic       rd_ready,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic       err,
    output logic       m_newd,
    output logic       m_wr,
    output logic [6:0] m_addr,
    output logic [7:0] m_wdata,
    input  logic [7:0] m_rdata,
    input  logic       m_done
);

    localparam int unsigned ADDR_W  = 7;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned LEN_W   = 4;
    localparam int unsigned MAX_A   = (NEWD_HOLD > TWR_CYCLES) ? NEWD_HOLD : TWR_CYCLES;
    localparam int unsigned CNT_MAX = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT,
        S_RPUSH,
        S_TWR,
        S_NEXT
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               wr_q, wr_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic [2:0]         sync_q;
    logic               done_edge;

    logic               cmd_ready_d, wd_ready_d, rd_valid_d, busy_d, err_d;
    logic               m_newd_d, m_wr_d;
    logic [DATA_W-1:0]  rd_data_d, m_wdata_d;
    logic [ADDR_W-1:0]  m_addr_d;

    // Helpers to start a byte transaction from any state
    logic               issue_go;
    logic [ADDR_W-1:0]  issue_addr;

`ifdef EEPROM_BURST_TIMEOUT_EN
    logic [CNT_W-1:0]   to_cnt_q, to_cnt_d;
`endif

    // Two synchronizer flops plus one history flop for rising-edge detect
    assign done_edge = sync_q[1] & ~sync_q[2];

    // State, counters and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            rem_q     <= '0;
            sync_q    <= '0;
            cmd_ready <= 1'b1;
            wd_ready  <= 1'b0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            busy      <= 1'b0;
            err       <= 1'b0;
            m_newd    <= 1'b0;
            m_wr      <= 1'b0;
            m_addr    <= '0;
            m_wdata   <= '0;
`ifdef EEPROM_BURST_TIMEOUT_EN
            to_cnt_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            sync_q    <= {sync_q[1:0], m_done};
            cmd_ready <= cmd_ready_d;
            wd_ready  <= wd_ready_d;
            rd_valid  <= rd_valid_d;
            rd_data   <= rd_data_d;
            busy      <= busy_d;
            err       <= err_d;
            m_newd    <= m_newd_d;
            m_wr      <= m_wr_d;
            m_addr    <= m_addr_d;
            m_wdata   <= m_wdata_d;
`ifdef EEPROM_BURST_TIMEOUT_EN
            to_cnt_q  <= to_cnt_d;
`endif
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        cmd_ready_d = 1'b0;
        wd_ready_d  = 1'b0;
        rd_valid_d  = rd_valid;
        rd_data_d   = rd_data;
        busy_d      = busy;
        err_d       = err;
        m_newd_d    = m_newd;
        m_wr_d      = m_wr;
        m_addr_d    = m_addr;
        m_wdata_d   = m_wdata;
        issue_go    = 1'b0;
        issue_addr  = addr_q;
`ifdef EEPROM_BURST_TIMEOUT_EN
        to_cnt_d    = to_cnt_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    wr_d   = cmd_wr;
                    addr_d = cmd_addr;
                    rem_d  = cmd_len;
                    err_d  = 1'b0;
                    busy_d = 1'b1;
                    if (cmd_wr) begin
                        state_d    = S_FETCH;
                        wd_ready_d = 1'b1;
                    end else begin
                        issue_go   = 1'b1;
                        issue_addr = cmd_addr;
                    end
                end else begin
                    cmd_ready_d = 1'b1;
                end
            end

            S_FETCH: begin
                if (wd_valid && wd_ready) begin
                    m_wdata_d = wd_data;
                    issue_go  = 1'b1;
                end else begin
                    wd_ready_d = 1'b1;
                end
            end

            // Done edges here belong to the previous byte and are ignored
            S_ISSUE: begin
                cnt_d = cnt_q + CNT_W'(1);
`ifdef EEPROM_BURST_TIMEOUT_EN
                to_cnt_d = to_cnt_q + CNT_W'(1);
`endif
                if (cnt_q == CNT_W'(NEWD_HOLD - 1)) begin
                    m_newd_d = 1'b0;
                    state_d  = S_WAIT;
                end
            end

            S_WAIT: begin
`ifdef EEPROM_BURST_TIMEOUT_EN
                to_cnt_d = to_cnt_q + CNT_W'(1);
`endif
                if (done_edge) begin
                    if (wr_q) begin
                        cnt_d   = '0;
                        state_d = S_TWR;
                    end else begin
                        rd_data_d  = m_rdata;
                        rd_valid_d = 1'b1;
                        state_d    = S_RPUSH;
                    end
                end
`ifdef EEPROM_BURST_TIMEOUT_EN
                else if (to_cnt_q >= CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    err_d       = 1'b1;
                    busy_d      = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = S_IDLE;
                end
`endif
            end

            S_RPUSH: begin
                if (rd_ready) begin
                    rd_valid_d = 1'b0;
                    state_d    = S_NEXT;
                end
            end

            S_TWR: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(TWR_CYCLES - 1)) begin
                    state_d = S_NEXT;
                end
            end

            S_NEXT: begin
                if (rem_q == '0) begin
                    busy_d      = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    rem_d  = rem_q - LEN_W'(1);
                    // 7-bit add wraps 127 back to 0
                    addr_d = addr_q + ADDR_W'(1);
                    if (wr_q) begin
                        state_d    = S_FETCH;
                        wd_ready_d = 1'b1;
                    end else begin
                        issue_go   = 1'b1;
                        issue_addr = addr_q + ADDR_W'(1);
                    end
                end
            end

            default: begin
                state_d     = S_IDLE;
                cmd_ready_d = 1'b1;
                busy_d      = 1'b0;
                m_newd_d    = 1'b0;
                rd_valid_d  = 1'b0;
            end
        endcase

        // Common entry into ISSUE: m_newd rises on the next cycle
        if (issue_go) begin
            state_d  = S_ISSUE;
            cnt_d    = '0;
            m_newd_d = 1'b1;
            m_addr_d = issue_addr;
            m_wr_d   = wr_d;
`ifdef EEPROM_BURST_TIMEOUT_EN
            to_cnt_d = '0;
`endif
        end
    end

endmodule
